coin_dispenser: RTL and testbench

- Downstream of the vending controller `vend`.
- Consumes its one-cycle change requests `return_5`/`return_10`/`return_25` and queues them per denomination.
- Fires tube solenoids one coin at a time with fixed pulse and gap timing.
- Tracks tube inventory from accepted-coin detects (`detect_5`/`detect_10`/`detect_25`) and reports `empty_5`/`empty_10`/`empty_25` back to `vend`.

---
 rtl/coin_pkg.sv | 22 ++
 rtl/coin_tube.sv | 47 ++++
 rtl/coin_dispenser.sv | 159 +++++++++++++++
 tb/tb_coin_dispenser.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared types and cent values for the coin dispenser: coin identifiers,
// dispenser FSM states and a coin-to-cents helper.
package coin_pkg;

  typedef enum logic [1:0] {COIN_NONE, COIN_5, COIN_10, COIN_25} coin_t;

  typedef enum logic [1:0] {IDLE, FIRE, GAP} disp_state_t;

  localparam logic [4:0] CENTS_5  = 5'd5;
  localparam logic [4:0] CENTS_10 = 5'd10;
  localparam logic [4:0] CENTS_25 = 5'd25;

  function automatic logic [4:0] coin_cents(input coin_t c);
    case (c)
      COIN_5:  return CENTS_5;
      COIN_10: return CENTS_10;
      COIN_25: return CENTS_25;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_tube.sv
// One coin tube: detect edge counting, saturating inventory, empty decode
// and the pending-request counter for this denomination.
module coin_tube #(
  parameter int TUBE_W     = 6,
  parameter int TUBE_MAX   = 63,
  parameter int INIT_COUNT = 0,
  parameter int PEND_W     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic detect,
  input  logic req,
  input  logic take,
  input  logic pop,
  output logic empty,
  output logic pending_nz,
  output logic lost
);

  localparam logic [TUBE_W-1:0] T_MAX    = TUBE_W'(TUBE_MAX);
  localparam logic [TUBE_W-1:0] T_INIT   = TUBE_W'(INIT_COUNT);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic              det_q;
  logic [TUBE_W-1:0] count;
  logic [PEND_W-1:0] pend;
  logic              inc;

  // An increment at capacity is dropped even when a coin leaves this cycle.
  assign inc        = detect && !det_q && (count != T_MAX);
  assign lost       = req && (pend == PEND_MAX) && !pop;
  assign empty      = (count == '0);
  assign pending_nz = (pend != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_q <= 1'b0;
      count <= T_INIT;
      pend  <= '0;
    end else begin
      det_q <= detect;
      count <= count + TUBE_W'(inc) - TUBE_W'(take);
      pend  <= pend + PEND_W'(req && !lost) - PEND_W'(pop);
    end
  end

endmodule

// File: rtl/coin_dispenser.sv
// Change dispenser: queues change requests per coin and pulses the tube
// solenoids one coin at a time. Optional statistics under COIN_DISP_STATS_EN.
module coin_dispenser
  import coin_pkg::*;
#(
  parameter int PULSE_CYC  = 20,
  parameter int GAP_CYC    = 10,
  parameter int TUBE_W     = 6,
  parameter int TUBE_MAX   = 63,
  parameter int INIT_COUNT = 0,
  parameter int PEND_W     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        detect_5,
  input  logic        detect_10,
  input  logic        detect_25,
  input  logic        return_5,
  input  logic        return_10,
  input  logic        return_25,
  output logic        sol_5,
  output logic        sol_10,
  output logic        sol_25,
  output logic        empty_5,
  output logic        empty_10,
  output logic        empty_25,
  output logic        busy,
  output logic        err_empty,
  output logic        err_ovf,
  output disp_state_t dbg_state
`ifdef COIN_DISP_STATS_EN
  ,
  output logic [15:0] disp_cents,
  output logic [7:0]  drop_cnt
`endif
);

  localparam int TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

  // Bit order everywhere: [0]=5c, [1]=10c, [2]=25c.
  logic [2:0] det_v, req_v, take_v, pop_v, empty_v, pnz_v, lost_v;
  logic [2:0] sol_q;

  disp_state_t      state;
  logic [TMR_W-1:0] timer;
  coin_t            sel_coin;
  logic [1:0]       sel_idx;
  logic             dispatch;
  logic             sel_stock;

  assign det_v = {detect_25, detect_10, detect_5};
  assign req_v = {return_25, return_10, return_5};

  for (genvar i = 0; i < 3; i++) begin : g_tube
    coin_tube #(
      .TUBE_W    (TUBE_W),
      .TUBE_MAX  (TUBE_MAX),
      .INIT_COUNT(INIT_COUNT),
      .PEND_W    (PEND_W)
    ) u_tube (
      .clk       (clk),
      .reset     (reset),
      .detect    (det_v[i]),
      .req       (req_v[i]),
      .take      (take_v[i]),
      .pop       (pop_v[i]),
      .empty     (empty_v[i]),
      .pending_nz(pnz_v[i]),
      .lost      (lost_v[i])
    );
  end

  // Highest-value coin wins so large change drains first.
  always_comb begin
    sel_coin = COIN_NONE;
    sel_idx  = 2'd0;
    if (pnz_v[2]) begin
      sel_coin = COIN_25;
      sel_idx  = 2'd2;
    end else if (pnz_v[1]) begin
      sel_coin = COIN_10;
      sel_idx  = 2'd1;
    end else if (pnz_v[0]) begin
      sel_coin = COIN_5;
      sel_idx  = 2'd0;
    end
  end

  assign dispatch  = (state == IDLE) && (sel_coin != COIN_NONE);
  assign sel_stock = !empty_v[sel_idx];
  assign pop_v     = dispatch ? (3'b001 << sel_idx) : 3'b000;
  assign take_v    = (dispatch && sel_stock) ? (3'b001 << sel_idx) : 3'b000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      sol_q     <= 3'b000;
      err_empty <= 1'b0;
      err_ovf   <= 1'b0;
`ifdef COIN_DISP_STATS_EN
      disp_cents <= 16'd0;
      drop_cnt   <= 8'd0;
`endif
    end else begin
      if (|lost_v) err_ovf <= 1'b1;
      case (state)
        IDLE: begin
          if (dispatch) begin
            if (sel_stock) begin
              state <= FIRE;
              sol_q <= pop_v;
              timer <= PULSE_LOAD;
`ifdef COIN_DISP_STATS_EN
              disp_cents <= disp_cents + 16'(coin_cents(sel_coin));
`endif
            end else begin
              err_empty <= 1'b1;
`ifdef COIN_DISP_STATS_EN
              if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
`endif
            end
          end
        end
        FIRE: begin
          if (timer == '0) begin
            state <= GAP;
            sol_q <= 3'b000;
            timer <= GAP_LOAD;
          end else begin
            timer <= timer - TMR_ONE;
          end
        end
        GAP: begin
          if (timer == '0) state <= IDLE;
          else             timer <= timer - TMR_ONE;
        end
        default: begin
          state <= IDLE;
          sol_q <= 3'b000;
        end
      endcase
    end
  end

  assign sol_5     = sol_q[0];
  assign sol_10    = sol_q[1];
  assign sol_25    = sol_q[2];
  assign empty_5   = empty_v[0];
  assign empty_10  = empty_v[1];
  assign empty_25  = empty_v[2];
  assign busy      = (state != IDLE) || (|pnz_v);
  assign dbg_state = state;

endmodule

// File: tb/tb_coin_dispenser.sv
// Bench for coin_dispenser: directed scenarios plus random traffic, checked
// against a timeline model of pending requests, tube stock and pulse windows.
module tb_coin_dispenser;
  import coin_pkg::*;

  localparam int P    = 20;
  localparam int G    = 10;
  localparam int TMAX = 63;
  localparam int PMAX = 15;
  localparam int INIT = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic detect_5 = 0, detect_10 = 0, detect_25 = 0;
  logic return_5 = 0, return_10 = 0, return_25 = 0;
  logic sol_5, sol_10, sol_25, empty_5, empty_10, empty_25;
  logic busy, err_empty, err_ovf;
  disp_state_t dbg_state;
`ifdef COIN_DISP_STATS_EN
  logic [15:0] disp_cents;
  logic [7:0]  drop_cnt;
`endif

  coin_dispenser dut (
    .clk(clk), .reset(reset),
    .detect_5(detect_5), .detect_10(detect_10), .detect_25(detect_25),
    .return_5(return_5), .return_10(return_10), .return_25(return_25),
    .sol_5(sol_5), .sol_10(sol_10), .sol_25(sol_25),
    .empty_5(empty_5), .empty_10(empty_10), .empty_25(empty_25),
    .busy(busy), .err_empty(err_empty), .err_ovf(err_ovf),
    .dbg_state(dbg_state)
`ifdef COIN_DISP_STATS_EN
    , .disp_cents(disp_cents), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: index 0=5c, 1=10c, 2=25c.
  int m_tube[3];
  int m_pend[3];
  int m_prev[3];
  bit m_erre, m_erro;
  int cyc, next_free, fire_start, cur;
  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_tube[i] = INIT;
      m_pend[i] = 0;
      m_prev[i] = 0;
    end
    m_erre = 0;
    m_erro = 0;
    cyc = 0;
    next_free = 0;
    fire_start = -1000;
    cur = 0;
  endtask

  task automatic compare_all();
    logic [2:0] esol, eempty;
    logic ebusy;
    esol = 3'b000;
    if (cyc >= fire_start && cyc < fire_start + P) esol[cur] = 1'b1;
    for (int i = 0; i < 3; i++) eempty[i] = (m_tube[i] == 0);
    ebusy = (cyc < next_free) || (m_pend[0] + m_pend[1] + m_pend[2] > 0);
    chk("sol", {5'b0, sol_25, sol_10, sol_5}, {5'b0, esol});
    chk("empty", {5'b0, empty_25, empty_10, empty_5}, {5'b0, eempty});
    chk("busy", {7'b0, busy}, {7'b0, ebusy});
    chk("err_empty", {7'b0, err_empty}, {7'b0, m_erre});
    chk("err_ovf", {7'b0, err_ovf}, {7'b0, m_erro});
  endtask

  // One clock of the specification's rules applied to the model.
  task automatic model_advance(input logic [2:0] det, input logic [2:0] ret);
    int pop[3];
    int dec[3];
    bit found;
    found = 0;
    for (int i = 0; i < 3; i++) begin
      pop[i] = 0;
      dec[i] = 0;
    end
    if (cyc >= next_free) begin
      for (int i = 2; i >= 0; i--) begin
        if (!found && m_pend[i] > 0) begin
          found = 1;
          pop[i] = 1;
          if (m_tube[i] > 0) begin
            dec[i] = 1;
            cur = i;
            fire_start = cyc + 1;
            next_free = cyc + 1 + P + G;
          end else begin
            m_erre = 1;
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (ret[i]) begin
        if (m_pend[i] - pop[i] < PMAX) m_pend[i] = m_pend[i] - pop[i] + 1;
        else begin
          m_erro = 1;
          m_pend[i] = m_pend[i] - pop[i];
        end
      end else begin
        m_pend[i] = m_pend[i] - pop[i];
      end
      if (det[i] && m_prev[i] == 0) m_tube[i] = m_tube[i] + 1;
      if (m_tube[i] > TMAX) m_tube[i] = TMAX;
      m_tube[i] = m_tube[i] - dec[i];
      m_prev[i] = det[i];
    end
    cyc++;
  endtask

  task automatic step(input logic [2:0] det, input logic [2:0] ret);
    compare_all();
    {detect_25, detect_10, detect_5} = det;
    {return_25, return_10, return_5} = ret;
    model_advance(det, ret);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(3'b000, 3'b000);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    {detect_25, detect_10, detect_5} = 3'b000;
    {return_25, return_10, return_5} = 3'b000;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    compare_all();
    chk("state_reset", {6'b0, dbg_state}, {6'b0, IDLE});
    reset = 1'b0;
  endtask

  logic [2:0] rdet;
  logic [2:0] rret;

  initial begin
    model_reset();
    reset_dut();

    // Refill: detect_10 held 10 cycles, three times.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 10; j++) step(3'b010, 3'b000);
      idle(3);
    end
    chk("tube10_model", 8'(m_tube[1]), 8'd3);

    // Priority: all tubes at 2, three requests together.
    reset_dut();
    for (int k = 0; k < 2; k++) begin
      step(3'b111, 3'b000);
      step(3'b000, 3'b000);
    end
    step(3'b000, 3'b111);
    idle(3 * (P + G + 1) + 5);

    // Empty drop: drain the 25c tube, then ask once more.
    step(3'b000, 3'b100);
    idle(P + G + 4);
    step(3'b000, 3'b100);
    idle(6);

    // Overflow: fill 5c tube to capacity, hold busy on a 10c coin, flood 5c.
    for (int k = 0; k < TMAX + 2; k++) begin
      step(3'b001, 3'b000);
      step(3'b000, 3'b000);
    end
    step(3'b000, 3'b010);
    for (int k = 0; k < 17; k++) step(3'b000, 3'b001);
    idle(16 * (P + G + 1) + 10);

    // Reset mid-FIRE on a 10c pulse.
    reset_dut();
    step(3'b010, 3'b000);
    step(3'b000, 3'b010);
    idle(6);
    #2 reset = 1'b1;
    #1 chk("sol_async_drop", {5'b0, sol_25, sol_10, sol_5}, 8'd0);
    @(negedge clk);
    model_reset();
    compare_all();
    reset = 1'b0;
    idle(40);

    // Random traffic: light, then heavy request load.
    reset_dut();
    rdet = 3'b000;
    for (int k = 0; k < 2300; k++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) == 0) rdet[i] = ~rdet[i];
        if (k < 1500) rret[i] = ($urandom_range(0, 24) == 0);
        else          rret[i] = ($urandom_range(0, 3) == 0);
      end
      step(rdet, rret);
    end
    idle(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
